// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial unsigned adder with valid/ready handshakes
// One 4-bit nibble is added per cycle; result is held under out_valid until consumed.
module nibble_serial_adder #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*N_NIB-1:0]   a,
  input  logic [4*N_NIB-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*N_NIB-1:0]   sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [N_NIB-1:0][3:0] a_q;
  logic [N_NIB-1:0][3:0] b_q;
  logic [N_NIB-1:0][3:0] sum_q;
  logic                  carry_q;
  logic                  cout_q;
  logic [IDX_W-1:0]      idx;
  logic                  last_nib;
  logic [4:0]            nib_sum;

  assign last_nib = (idx == LAST_IDX);
  assign nib_sum  = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {4'b0000, carry_q};
  assign sum      = sum_q;
  assign cout     = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_n = ADD;
        end
      end
      ADD: begin
        if (last_nib) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Operands are captured only on the accept edge so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
          end
        end
        ADD: begin
          sum_q[idx] <= nib_sum[3:0];
          carry_q    <= nib_sum[4];
          if (last_nib) begin
            cout_q <= nib_sum[4];
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  int checks;
  int failures;

  nibble_serial_adder #(.N_NIB(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, scramble inputs during ADD, check latency and result.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec, input int hold);
    int lat;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~va; b = va ^ 16'h5A5A; cin = ~vc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_sum"}, {15'd0, cout, sum}, {15'd0, ec, es});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_retain"}, {15'd0, cout, sum}, {15'd0, ec, es});
  endtask

  logic [15:0] va_t [4] = '{16'h0001, 16'h000F, 16'h8888, 16'hFFFF};
  logic [15:0] vb_t [4] = '{16'h0001, 16'h0000, 16'h8888, 16'h0001};
  logic        vc_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [16:0] ex_t [4] = '{17'h00002, 17'h00010, 17'h11110, 17'h10000};

  initial begin
    int seen;
    int sent;
    int cyc;
    int last_cyc;
    bit aborted_valid;
    checks = 0;
    failures = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", {15'd0, cout, sum}, 32'd0);

    run_op("one_plus_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);
    run_op("carry_n0_n1", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op("eights", 16'h8888, 16'h8888, 1'b0, 16'h1110, 1'b1, 3);

    // Abort mid-ADD after two nibbles have been processed.
    a = 16'h0FFF; b = 16'h0FFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    tick(); tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_sum", {15'd0, cout, sum}, 32'd0);
    aborted_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) aborted_valid = 1'b1;
      tick();
    end
    chk("abort_no_valid", 32'(aborted_valid), 32'd0);
    run_op("after_abort", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high.
    seen = 0; sent = 0; last_cyc = -1;
    out_ready = 1'b1; in_valid = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        if (seen < 4) chk("b2b_result", {15'd0, cout, sum}, {15'd0, ex_t[seen]});
        if (last_cyc >= 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        seen++;
      end
      if (in_ready) begin
        if (sent < 4) begin
          a = va_t[sent]; b = vb_t[sent]; cin = vc_t[sent];
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_count", 32'(seen), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
